key_filter: RTL and testbench

//   Debounces one raw mechanical push-button (active-low) into a clean pressed level
//   and a one-cycle press pulse.

---
 rtl/key_filter.sv | 127 ++++++++++++
 tb/tb_key_filter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/key_filter.sv
// Debounces an active-low push-button into a clean pressed level and a one-cycle press pulse.
// Optional long-press pulse generation is enabled by defining LONG_PRESS_EN.
module key_filter #(
  parameter int unsigned CNT_MAX  = 999_999,
  parameter int unsigned LONG_MAX = 49_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_flag,
  output logic key_state,
  output logic key_long
);

  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  if (CNT_MAX == 0 || LONG_MAX < 2) begin : g_bad_params
    $error("key_filter: CNT_MAX must be >0 and LONG_MAX >= 2");
  end

  logic [1:0]       sync_q;
  logic             key_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_state_d;
  logic             key_flag_d;

  // Two-flop synchroniser; idles released (1) so reset never looks like a press
  always_ff @(posedge sys_clk) begin
    if (sys_rst) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], key_in};
  end

  assign key_s = ~sync_q[1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_state <= 1'b0;
      key_flag  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_state <= key_state_d;
      key_flag  <= key_flag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_state_d = key_state;
    key_flag_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = PRESS_FILT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_FILT: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(CNT_MAX)) begin
          state_d     = DOWN;
          key_state_d = 1'b1;
          key_flag_d  = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        if (!key_s) begin
          state_d = REL_FILT;
          cnt_d   = CNT_W'(1);
        end
      end
      REL_FILT: begin
        if (key_s) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(CNT_MAX)) begin
          state_d     = IDLE;
          key_state_d = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef LONG_PRESS_EN
  localparam int unsigned LCNT_W = $clog2(LONG_MAX + 1);

  logic [LCNT_W-1:0] lcnt_q;

  // Hold counter runs while pressed and parks at LONG_MAX so only one pulse per press
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lcnt_q   <= '0;
      key_long <= 1'b0;
    end else begin
      key_long <= key_state && (lcnt_q == LCNT_W'(LONG_MAX - 1));
      if (!key_state)                       lcnt_q <= '0;
      else if (lcnt_q != LCNT_W'(LONG_MAX)) lcnt_q <= lcnt_q + LCNT_W'(1);
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_filter.sv
// Self-checking bench for key_filter: directed phases plus random key patterns,
// compared every cycle against a run-length reference model.
module tb_key_filter;

  localparam int unsigned CNT_MAX  = 4;
  localparam int unsigned LONG_MAX = 20;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_in  = 1'b1;
  logic key_flag, key_state, key_long;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic m_s1 = 1'b1, m_s2 = 1'b1;
  logic m_state = 1'b0, m_flag = 1'b0, m_long = 1'b0;
  int   m_run = 0, m_hold = 0;
  int   flags_seen = 0, longs_seen = 0;
  int   cyc = 0;

  key_filter #(.CNT_MAX(CNT_MAX), .LONG_MAX(LONG_MAX)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_in   (key_in),
    .key_flag (key_flag),
    .key_state(key_state),
    .key_long (key_long)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Model: a level change is accepted after CNT_MAX+1 consecutive samples of the new level
  task automatic model_edge(input logic k, input logic r);
    logic ks;
    if (r) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_state = 1'b0; m_flag = 1'b0; m_long = 1'b0;
      m_run = 0; m_hold = 0;
    end else begin
      ks     = ~m_s2;
      m_flag = 1'b0;
      m_long = 1'b0;
      if (m_state) begin
        m_hold++;
`ifdef LONG_PRESS_EN
        if (m_hold == int'(LONG_MAX)) m_long = 1'b1;
`endif
      end else begin
        m_hold = 0;
      end
      if (ks != m_state) begin
        m_run++;
        if (m_run == int'(CNT_MAX) + 1) begin
          m_state = ks;
          m_flag  = ks;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = k;
    end
  endtask

  task automatic step(input logic k, input logic r);
    key_in  = k;
    sys_rst = r;
    @(posedge sys_clk);
    cyc++;
    model_edge(k, r);
    #1;
    if (key_flag === 1'b1) flags_seen++;
    if (key_long === 1'b1) longs_seen++;
    check("key_flag", key_flag, m_flag);
    check("key_state", key_state, m_state);
    check("key_long", key_long, m_long);
  endtask

  task automatic hold(input logic k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0);
  endtask

  initial begin
    int fl0, lg0, rise_cyc;

    // 1: reset held 3 cycles, key released
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    hold(1'b1, 5);

    // 2: clean press, 30 cycles; flag lands 6 edges after first low sample (7th edge counting it)
    fl0 = flags_seen;
    step(1'b0, 1'b0);
    rise_cyc = -1;
    for (int i = 0; i < 29; i++) begin
      step(1'b0, 1'b0);
      if (key_flag === 1'b1 && rise_cyc < 0) rise_cyc = i + 1;
    end
    check("press_flag_count", 1'(flags_seen - fl0 == 1), 1'b1);
    check("press_latency", 1'(rise_cyc == int'(CNT_MAX) + 2), 1'b1);

    // 4: release; no flag on release
    fl0 = flags_seen;
    hold(1'b1, 20);
    check("release_no_flag", 1'(flags_seen == fl0), 1'b1);
    check("released_level", key_state, 1'b0);

    // 3: bounce every 2 cycles for 20 cycles, then stay released
    fl0 = flags_seen;
    for (int i = 0; i < 10; i++) hold(1'(i % 2), 2);
    hold(1'b1, 10);
    check("bounce_no_flag", 1'(flags_seen == fl0), 1'b1);

    // 5: reset mid-filter with key held low, then full re-qualification
    hold(1'b0, 5);
    step(1'b0, 1'b1);
    fl0 = flags_seen;
    hold(1'b0, 20);
    check("requal_flag_count", 1'(flags_seen - fl0 == 1), 1'b1);
    hold(1'b1, 20);

    // 6: long hold of 60 cycles, including a short release bounce mid-hold
    fl0 = flags_seen;
    lg0 = longs_seen;
    hold(1'b0, 12);
    hold(1'b1, 2);
    hold(1'b0, 46);
    check("long_hold_flag_count", 1'(flags_seen - fl0 == 1), 1'b1);
`ifdef LONG_PRESS_EN
    check("long_pulse_count", 1'(longs_seen - lg0 == 1), 1'b1);
`else
    check("long_pulse_count", 1'(longs_seen - lg0 == 0), 1'b1);
`endif
    hold(1'b1, 20);

    // Random bursts of both levels, lengths around the filter window
    for (int seg = 0; seg < 150; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      if ($urandom_range(0, 29) == 0) step(lvl, 1'b1);
      hold(lvl, len);
    end
    hold(1'b1, 20);
    check("final_released", key_state, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
